// File: rtl/my_trap_csr_unit.sv
// Machine-mode CSR file (mstatus/misa/mtvec/mepc/mcause) and trap responder for the RV32I core.
// Optional external-interrupt trapping is enabled by defining MY_TRAP_EXT_IRQ_EN.
//
// state | meaning
// IDLE  | normal operation, CSR accesses and new requests accepted
// TRAP  | redirect fetch to the trap vector
// MRET  | redirect fetch to mepc
// WFI   | pipeline held until irq_ext
module my_trap_csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_valid_i,
  input  logic        wfi_valid_i,
  input  logic        irq_ext_i,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MISA    = 12'h301;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [4:0] IRQ_EXT_CODE = 5'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TRAP = 2'b01,
    S_MRET = 2'b10,
    S_WFI  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic        mcause_irq_q, mcause_irq_d;
  logic [4:0]  mcause_code_q, mcause_code_d;

  logic [31:0] mstatus_view;
  logic [31:0] mcause_view;
  logic [31:0] csr_new;
  logic        csr_impl;
  logic        csr_we;
  logic        irq_take;
  logic        wfi_irq_trap;

  // MPP is hardwired to machine mode
  assign mstatus_view = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mcause_view  = {mcause_irq_q, 26'b0, mcause_code_q};

  always_comb begin
    csr_impl    = 1'b1;
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      ADDR_MSTATUS: csr_rdata_o = mstatus_view;
      ADDR_MISA:    csr_rdata_o = MISA_VALUE;
      ADDR_MTVEC:   csr_rdata_o = mtvec_q;
      ADDR_MEPC:    csr_rdata_o = mepc_q;
      ADDR_MCAUSE:  csr_rdata_o = mcause_view;
      default:      csr_impl    = 1'b0;
    endcase
  end

  assign csr_illegal_o = (csr_op_i != OP_NONE) && !csr_impl;

  always_comb begin
    csr_new = csr_rdata_o;
    case (csr_op_i)
      OP_RW:   csr_new = csr_wdata_i;
      OP_RS:   csr_new = csr_rdata_o | csr_wdata_i;
      OP_RC:   csr_new = csr_rdata_o & ~csr_wdata_i;
      default: csr_new = csr_rdata_o;
    endcase
  end

`ifdef MY_TRAP_EXT_IRQ_EN
  assign irq_take     = (state_q == S_IDLE) && irq_ext_i && mie_q &&
                        !exc_valid_i && !mret_valid_i && !wfi_valid_i;
  assign wfi_irq_trap = (state_q == S_WFI) && irq_ext_i && mie_q;
`else
  assign irq_take     = 1'b0;
  assign wfi_irq_trap = 1'b0;
`endif

  // An instruction that traps (exception or interrupt) must not commit its CSR write
  assign csr_we = (state_q == S_IDLE) && !exc_valid_i && !irq_take &&
                  (csr_op_i != OP_NONE) && !csr_illegal_o;

  always_comb begin
    state_d          = state_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_irq_d     = mcause_irq_q;
    mcause_code_d    = mcause_code_q;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (csr_we) begin
          case (csr_addr_i)
            ADDR_MSTATUS: begin
              mie_d  = csr_new[3];
              mpie_d = csr_new[7];
            end
            ADDR_MTVEC:  mtvec_d = csr_new & ~32'h3;
            ADDR_MEPC:   mepc_d  = csr_new & ~32'h3;
            ADDR_MCAUSE: begin
              mcause_irq_d  = csr_new[31];
              mcause_code_d = csr_new[4:0];
            end
            default: ;
          endcase
        end

        if (exc_valid_i) begin
          stall_o       = 1'b1;
          mepc_d        = exc_pc_i & ~32'h3;
          mcause_irq_d  = 1'b0;
          mcause_code_d = exc_cause_i;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          state_d       = S_TRAP;
        end else if (mret_valid_i) begin
          stall_o = 1'b1;
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          state_d = S_MRET;
        end else if (wfi_valid_i) begin
          stall_o = 1'b1;
          state_d = S_WFI;
        end else if (irq_take) begin
          stall_o       = 1'b1;
          mepc_d        = exc_pc_i & ~32'h3;
          mcause_irq_d  = 1'b1;
          mcause_code_d = IRQ_EXT_CODE;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          state_d       = S_TRAP;
        end
      end

      S_TRAP: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mtvec_q & ~32'h3;
        state_d          = S_IDLE;
      end

      S_MRET: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mepc_q;
        state_d          = S_IDLE;
      end

      S_WFI: begin
        stall_o = 1'b1;
        // Wake is level-sensitive and independent of MIE; trapping on wake needs MIE
        if (wfi_irq_trap) begin
          mepc_d        = exc_pc_i & ~32'h3;
          mcause_irq_d  = 1'b1;
          mcause_code_d = IRQ_EXT_CODE;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          state_d       = S_TRAP;
        end else if (irq_ext_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= RESET_MTVEC & ~32'h3;
      mepc_q        <= 32'h0;
      mcause_irq_q  <= 1'b0;
      mcause_code_q <= 5'h0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_irq_q  <= mcause_irq_d;
      mcause_code_q <= mcause_code_d;
    end
  end

endmodule

// File: tb/tb_my_trap_csr_unit.sv
// Bench for my_trap_csr_unit: directed scenarios then random traffic against an
// architectural model of the trap CSRs.
module tb_my_trap_csr_unit;

  localparam logic [31:0] RESET_MTVEC = 32'h0000_0000;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  localparam int RUNNING   = 0;
  localparam int TRAPPED   = 1;
  localparam int RETURNING = 2;
  localparam int SLEEPING  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        exc_valid_i;
  logic [4:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        mret_valid_i;
  logic        wfi_valid_i;
  logic        irq_ext_i;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  int          m_mode;

  my_trap_csr_unit #(
    .RESET_MTVEC(RESET_MTVEC),
    .MISA_VALUE (MISA_VALUE)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .csr_op_i        (csr_op_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rdata_o     (csr_rdata_o),
    .csr_illegal_o   (csr_illegal_o),
    .exc_valid_i     (exc_valid_i),
    .exc_cause_i     (exc_cause_i),
    .exc_pc_i        (exc_pc_i),
    .mret_valid_i    (mret_valid_i),
    .wfi_valid_i     (wfi_valid_i),
    .irq_ext_i       (irq_ext_i),
    .stall_o         (stall_o),
    .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o   (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return MISA_VALUE;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_impl(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h301) || (a == 12'h305) ||
           (a == 12'h341) || (a == 12'h342);
  endfunction

  task automatic model_reset();
    m_mstatus = 32'h0000_1800;
    m_mtvec   = RESET_MTVEC & ~32'h3;
    m_mepc    = 32'h0;
    m_mcause  = 32'h0;
    m_mode    = RUNNING;
  endtask

  task automatic model_capture(input logic [31:0] pc, input logic [31:0] cause);
    m_mepc    = pc & ~32'h3;
    m_mcause  = cause;
    m_mstatus = 32'h0000_1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
  endtask

  task automatic inputs_idle();
    csr_op_i     = 2'b00;
    csr_addr_i   = 12'h000;
    csr_wdata_i  = 32'h0;
    exc_valid_i  = 1'b0;
    exc_cause_i  = 5'd0;
    exc_pc_i     = 32'h0;
    mret_valid_i = 1'b0;
    wfi_valid_i  = 1'b0;
    irq_ext_i    = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; compares, advances the model
  // across the next rising edge, and returns at the following falling edge.
  task automatic tick(input string tag, input logic [31:0] rd_exp, input bit use_rd);
    logic [31:0] nv, rpc;
    bit          take_irq, exp_stall, exp_rv, exp_ill;
    #1;
`ifdef MY_TRAP_EXT_IRQ_EN
    take_irq = irq_ext_i && m_mstatus[3] && !exc_valid_i && !mret_valid_i && !wfi_valid_i;
`else
    take_irq = 1'b0;
`endif
    rpc = 32'h0;
    case (m_mode)
      TRAPPED:   begin exp_stall = 1; exp_rv = 1; rpc = m_mtvec & ~32'h3; end
      RETURNING: begin exp_stall = 1; exp_rv = 1; rpc = m_mepc; end
      SLEEPING:  begin exp_stall = 1; exp_rv = 0; end
      default:   begin
        exp_stall = exc_valid_i || mret_valid_i || wfi_valid_i || take_irq;
        exp_rv    = 0;
      end
    endcase
    exp_ill = (csr_op_i != 2'b00) && !m_impl(csr_addr_i);
    check_eq("stall", 32'(stall_o), 32'(exp_stall));
    check_eq("redirect_valid", 32'(redirect_valid_o), 32'(exp_rv));
    if (exp_rv) check_eq("redirect_pc", redirect_pc_o, rpc);
    check_eq("rdata", csr_rdata_o, m_read(csr_addr_i));
    check_eq("illegal", 32'(csr_illegal_o), 32'(exp_ill));
    if (use_rd) check_eq(tag, csr_rdata_o, rd_exp);

    case (m_mode)
      RUNNING: begin
        if (exc_valid_i) begin
          model_capture(exc_pc_i, {27'b0, exc_cause_i});
          m_mode = TRAPPED;
        end else begin
          if (csr_op_i != 2'b00 && m_impl(csr_addr_i) && !take_irq) begin
            case (csr_op_i)
              2'b01:   nv = csr_wdata_i;
              2'b10:   nv = m_read(csr_addr_i) | csr_wdata_i;
              default: nv = m_read(csr_addr_i) & ~csr_wdata_i;
            endcase
            case (csr_addr_i)
              12'h300: m_mstatus = 32'h0000_1800 | (nv & 32'h88);
              12'h305: m_mtvec   = nv & ~32'h3;
              12'h341: m_mepc    = nv & ~32'h3;
              12'h342: m_mcause  = nv & 32'h8000_001F;
              default: ;
            endcase
          end
          if (mret_valid_i) begin
            m_mstatus = 32'h0000_1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            m_mode = RETURNING;
          end else if (wfi_valid_i) begin
            m_mode = SLEEPING;
          end else if (take_irq) begin
            model_capture(exc_pc_i, 32'h8000_000B);
            m_mode = TRAPPED;
          end
        end
      end
      SLEEPING: begin
        if (irq_ext_i) begin
`ifdef MY_TRAP_EXT_IRQ_EN
          if (m_mstatus[3]) begin
            model_capture(exc_pc_i, 32'h8000_000B);
            m_mode = TRAPPED;
          end else begin
            m_mode = RUNNING;
          end
`else
          m_mode = RUNNING;
`endif
        end
      end
      default: m_mode = RUNNING;
    endcase
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    inputs_idle();
    csr_addr_i = a;
    tick(tag, exp, 1);
  endtask

  task automatic csr_access(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    inputs_idle();
    csr_op_i    = op;
    csr_addr_i  = a;
    csr_wdata_i = wd;
    tick("csr_access", 32'h0, 0);
  endtask

  logic [11:0] addr_pool [7];
  logic [4:0]  cause_pool [3];
  int          rnd;

  initial begin
    addr_pool  = '{12'h300, 12'h301, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h000};
    cause_pool = '{5'd0, 5'd2, 5'd11};

    rst_i = 1'b1;
    inputs_idle();
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // reset view
    #1;
    check_eq("rst_stall", 32'(stall_o), 32'h0);
    check_eq("rst_redirect", 32'(redirect_valid_o), 32'h0);
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_misa", 12'h301, 32'h4000_0100);
    peek("rst_mtvec", 12'h305, RESET_MTVEC);

    // CSR writes with masking
    csr_access(2'b01, 12'h305, 32'h0000_0103);
    csr_access(2'b10, 12'h300, 32'h0000_0008);
    peek("mtvec_masked", 12'h305, 32'h0000_0100);
    peek("mstatus_mie", 12'h300, 32'h0000_1808);
    csr_access(2'b01, 12'h301, 32'hFFFF_FFFF);
    peek("misa_ro", 12'h301, 32'h4000_0100);

    // ECALL trap
    inputs_idle();
    exc_valid_i = 1'b1;
    exc_cause_i = 5'd11;
    exc_pc_i    = 32'h0000_0044;
    tick("ecall", 32'h0, 0);
    inputs_idle();
    #1;
    check_eq("trap_rv", 32'(redirect_valid_o), 32'h1);
    check_eq("trap_pc", redirect_pc_o, 32'h0000_0100);
    tick("trap_cycle", 32'h0, 0);
    peek("ecall_mepc", 12'h341, 32'h0000_0044);
    peek("ecall_mcause", 12'h342, 32'h0000_000B);
    peek("ecall_mstatus", 12'h300, 32'h0000_1880);

    // MRET
    inputs_idle();
    mret_valid_i = 1'b1;
    tick("mret", 32'h0, 0);
    inputs_idle();
    #1;
    check_eq("mret_rv", 32'(redirect_valid_o), 32'h1);
    check_eq("mret_pc", redirect_pc_o, 32'h0000_0044);
    tick("mret_cycle", 32'h0, 0);
    peek("mret_mstatus", 12'h300, 32'h0000_1888);

    // exception with a concurrent CSR write: the write is dropped
    inputs_idle();
    exc_valid_i = 1'b1;
    exc_cause_i = 5'd2;
    exc_pc_i    = 32'h0000_0123;
    csr_op_i    = 2'b01;
    csr_addr_i  = 12'h341;
    csr_wdata_i = 32'hDEAD_BEEF;
    tick("exc_with_csr", 32'h0, 0);
    inputs_idle();
    tick("trap2_cycle", 32'h0, 0);
    peek("drop_mepc", 12'h341, 32'h0000_0120);
    peek("drop_mcause", 12'h342, 32'h0000_0002);

    // unimplemented CSR
    inputs_idle();
    csr_op_i    = 2'b01;
    csr_addr_i  = 12'h7C0;
    csr_wdata_i = 32'hFFFF_FFFF;
    #1;
    check_eq("illegal_7c0", 32'(csr_illegal_o), 32'h1);
    tick("illegal_access", 32'h0, 0);
    peek("illegal_keep_mstatus", 12'h300, 32'h0000_1880);
    peek("illegal_keep_mtvec", 12'h305, 32'h0000_0100);

    csr_access(2'b01, 12'h342, 32'hFFFF_FFFF);
    peek("mcause_mask", 12'h342, 32'h8000_001F);

    // WFI with a delayed wake, MIE set
    csr_access(2'b10, 12'h300, 32'h0000_0008);
    inputs_idle();
    wfi_valid_i = 1'b1;
    tick("wfi_accept", 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      inputs_idle();
      wfi_valid_i = 1'b1;
      #1;
      check_eq("wfi_stall", 32'(stall_o), 32'h1);
      tick("wfi_wait", 32'h0, 0);
    end
    inputs_idle();
    irq_ext_i = 1'b1;
    exc_pc_i  = 32'h0000_0208;
    tick("wfi_wake", 32'h0, 0);
    inputs_idle();
    #1;
`ifdef MY_TRAP_EXT_IRQ_EN
    check_eq("wake_trap_rv", 32'(redirect_valid_o), 32'h1);
    check_eq("wake_trap_pc", redirect_pc_o, 32'h0000_0100);
    tick("wake_trap_cycle", 32'h0, 0);
    peek("wake_mcause", 12'h342, 32'h8000_000B);
    peek("wake_mepc", 12'h341, 32'h0000_0208);
`else
    check_eq("wake_idle_stall", 32'(stall_o), 32'h0);
    peek("wake_mstatus", 12'h300, 32'h0000_1888);
`endif

    // reset while in TRAP
    inputs_idle();
    exc_valid_i = 1'b1;
    exc_cause_i = 5'd0;
    exc_pc_i    = 32'h0000_0200;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    inputs_idle();
    csr_addr_i = 12'h341;
    #1;
    check_eq("rst_trap_rv", 32'(redirect_valid_o), 32'h0);
    check_eq("rst_trap_stall", 32'(stall_o), 32'h0);
    check_eq("rst_trap_mepc", csr_rdata_o, 32'h0);
    @(negedge clk_i);
    check_eq("rst_hold_rv", 32'(redirect_valid_o), 32'h0);
    model_reset();
    rst_i = 1'b0;
    #1;
    check_eq("post_rst_rv", 32'(redirect_valid_o), 32'h0);
    check_eq("post_rst_stall", 32'(stall_o), 32'h0);
    tick("post_rst", 32'h0, 0);
    peek("post_rst_mtvec", 12'h305, RESET_MTVEC);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      inputs_idle();
      rnd          = $urandom_range(0, 99);
      exc_valid_i  = (rnd < 8);
      mret_valid_i = (rnd >= 8) && (rnd < 16);
      wfi_valid_i  = (rnd >= 16) && (rnd < 22);
      irq_ext_i    = ($urandom_range(0, 9) < 3);
      exc_cause_i  = cause_pool[$urandom_range(0, 2)];
      exc_pc_i     = $urandom;
      csr_addr_i   = addr_pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) csr_addr_i = 12'($urandom);
      csr_wdata_i  = $urandom;
      csr_op_i     = (mret_valid_i || wfi_valid_i) ? 2'b00 : 2'($urandom_range(0, 3));
      tick("rand", 32'h0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
